// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue instruction buffer between fetch and decode.
// Circular buffer with wrap-bit pointers; occupancy is derived from the pointer difference.
module fetch_queue #(
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             flush_i,
    input  logic             push_valid_0_i,
    input  logic             push_valid_1_i,
    input  logic [31:0]      push_inst_0_i,
    input  logic [31:0]      push_inst_1_i,
    input  logic [31:0]      push_pc_0_i,
    input  logic [31:0]      push_pc_1_i,
    input  logic             push_pred_taken_0_i,
    input  logic             push_pred_taken_1_i,
    output logic             push_ready_o,
    input  logic             pop_i,
    output logic [31:0]      inst0_o,
    output logic [31:0]      inst1_o,
    output logic [31:0]      pc_0_o,
    output logic [31:0]      pc_1_o,
    output logic             pred_taken_0_o,
    output logic             pred_taken_1_o,
    output logic             was_fetched_0_o,
    output logic             was_fetched_1_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int IDX_W = CNT_W - 1;

    logic [CNT_W-1:0] rd_q, rd_d, wr_q, wr_d, count, n_push, n_pop;
    logic [IDX_W-1:0] ri0, ri1, wi0, wi1;
    logic             push_acc;
    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic             pt_mem   [DEPTH];

    always_comb begin
        count           = wr_q - rd_q;
        ri0             = rd_q[IDX_W-1:0];
        ri1             = rd_q[IDX_W-1:0] + IDX_W'(1);
        wi0             = wr_q[IDX_W-1:0];
        wi1             = wr_q[IDX_W-1:0] + IDX_W'(1);
        push_ready_o    = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
        was_fetched_0_o = count != '0;
        was_fetched_1_o = count >= CNT_W'(2);
        n_push          = push_valid_0_i ? (push_valid_1_i ? CNT_W'(2) : CNT_W'(1)) : '0;
        n_pop           = pop_i ? CNT_W'(was_fetched_0_o) + CNT_W'(was_fetched_1_o) : '0;
        push_acc        = push_ready_o && push_valid_0_i && !flush_i;
        // Flush drops everything, including this cycle's push.
        wr_d            = push_acc ? wr_q + n_push : wr_q;
        rd_d            = flush_i ? wr_q : rd_q + n_pop;
        inst0_o         = was_fetched_0_o ? inst_mem[ri0] : '0;
        pc_0_o          = was_fetched_0_o ? pc_mem[ri0] : '0;
        pred_taken_0_o  = was_fetched_0_o && pt_mem[ri0];
        inst1_o         = was_fetched_1_o ? inst_mem[ri1] : '0;
        pc_1_o          = was_fetched_1_o ? pc_mem[ri1] : '0;
        pred_taken_1_o  = was_fetched_1_o && pt_mem[ri1];
        count_o         = count;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_q <= '0;
            wr_q <= '0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_acc) begin
            inst_mem[wi0] <= push_inst_0_i;
            pc_mem[wi0]   <= push_pc_0_i;
            pt_mem[wi0]   <= push_pred_taken_0_i;
            if (push_valid_1_i) begin
                inst_mem[wi1] <= push_inst_1_i;
                pc_mem[wi1]   <= push_pc_1_i;
                pt_mem[wi1]   <= push_pred_taken_1_i;
            end
        end
    end
endmodule
